// File: rtl/hazard_pkg.sv
// Shared hazard-control types and default sizes, also used by the forwarding
// unit and decode.
package hazard_pkg;

   localparam int REG_W_DEF     = 4;
   localparam int DRAIN_CYC_DEF = 3;
   localparam int CNT_W_DEF     = 16;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      DRAIN    = 2'd2,
      HALTED   = 2'd3
   } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over the increment.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_inc,
   input  logic         i_clr,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != '1)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use stalls, memory-wait freeze,
// taken-branch squash and halt/drain/resume sequencing, plus a stall counter.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_W     = REG_W_DEF,
   parameter int DRAIN_CYC = DRAIN_CYC_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] i_id_rs1,
   input  logic [REG_W-1:0] i_id_rs2,
   input  logic             i_id_rs1_vld,
   input  logic             i_id_rs2_vld,
   input  logic [REG_W-1:0] i_ex_reg_dst,
   input  logic             i_ex_wr,
   input  logic             i_ex_is_load,
   input  logic             i_ex_br_taken,
   input  logic             i_mem_req,
   input  logic             i_mem_ack,
   input  logic             i_id_halt,
   input  logic             i_resume,
   input  logic             i_stall_cnt_clr,
   output logic             o_pc_hold,
   output logic             o_if_id_hold,
   output logic             o_id_ex_hold,
   output logic             o_ex_mem_hold,
   output logic             o_if_id_flush,
   output logic             o_id_ex_flush,
   output logic             o_id_ex_bubble,
   output logic             o_mem_wb_bubble,
   output logic             o_halted,
   output logic [CNT_W-1:0] o_stall_cnt
);

   localparam int DW = $clog2(DRAIN_CYC + 1);
   localparam logic [DW-1:0] LP_DRAIN = DW'(DRAIN_CYC);

   hz_state_t     r_state, w_state_next;
   logic [DW-1:0] r_drain, w_drain_next;

   logic w_mem_stall, w_src_match, w_load_use, w_halt_go;
   logic w_pc_hold, w_if_id_hold, w_id_ex_hold, w_ex_mem_hold;
   logic w_if_id_flush, w_id_ex_flush, w_id_ex_bubble, w_mem_wb_bubble, w_halted;

   assign w_mem_stall = (((r_state == RUN) || (r_state == DRAIN)) && i_mem_req && !i_mem_ack)
                      || ((r_state == MEM_WAIT) && !i_mem_ack);

   assign w_src_match = (i_id_rs1_vld && (i_id_rs1 == i_ex_reg_dst))
                      || (i_id_rs2_vld && (i_id_rs2 == i_ex_reg_dst));

   // A taken branch squashes the ID instruction, so its hazard is moot.
   assign w_load_use = !w_mem_stall && !i_ex_br_taken && i_ex_is_load && i_ex_wr && w_src_match;
   assign w_halt_go  = (r_state == RUN) && i_id_halt && !w_mem_stall && !i_ex_br_taken && !w_load_use;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= RUN;
         r_drain <= '0;
      end else begin
         r_state <= w_state_next;
         r_drain <= w_drain_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_drain_next    = r_drain;
      w_pc_hold       = 1'b0;
      w_if_id_hold    = 1'b0;
      w_id_ex_hold    = 1'b0;
      w_ex_mem_hold   = 1'b0;
      w_if_id_flush   = 1'b0;
      w_id_ex_flush   = 1'b0;
      w_id_ex_bubble  = 1'b0;
      w_mem_wb_bubble = 1'b0;
      w_halted        = 1'b0;
      if (w_mem_stall) begin
         w_pc_hold       = 1'b1;
         w_if_id_hold    = 1'b1;
         w_id_ex_hold    = 1'b1;
         w_ex_mem_hold   = 1'b1;
         w_mem_wb_bubble = 1'b1;
         if (r_state == RUN) begin
            w_state_next = MEM_WAIT;
         end
      end else begin
         if (i_ex_br_taken) begin
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
         end else if (w_load_use) begin
            w_pc_hold      = 1'b1;
            w_if_id_hold   = 1'b1;
            w_id_ex_bubble = 1'b1;
         end
         case (r_state)
            RUN: begin
               if (w_halt_go) begin
                  w_pc_hold     = 1'b1;
                  w_if_id_flush = 1'b1;
                  w_drain_next  = LP_DRAIN;
                  w_state_next  = DRAIN;
               end
            end
            MEM_WAIT: w_state_next = RUN;
            DRAIN: begin
               w_pc_hold     = 1'b1;
               w_if_id_flush = 1'b1;
               w_drain_next  = r_drain - 1'b1;
               if (r_drain <= 1) begin
                  w_state_next = HALTED;
               end
            end
            HALTED: begin
               w_pc_hold     = 1'b1;
               w_if_id_flush = 1'b1;
               w_halted      = 1'b1;
               if (i_resume) begin
                  w_state_next = RUN;
               end
            end
            default: w_state_next = RUN;
         endcase
      end
   end

   // Outputs are forced low for the whole time reset is asserted.
   assign o_pc_hold       = w_pc_hold       & rst_n;
   assign o_if_id_hold    = w_if_id_hold    & rst_n;
   assign o_id_ex_hold    = w_id_ex_hold    & rst_n;
   assign o_ex_mem_hold   = w_ex_mem_hold   & rst_n;
   assign o_if_id_flush   = w_if_id_flush   & rst_n;
   assign o_id_ex_flush   = w_id_ex_flush   & rst_n;
   assign o_id_ex_bubble  = w_id_ex_bubble  & rst_n;
   assign o_mem_wb_bubble = w_mem_wb_bubble & rst_n;
   assign o_halted        = w_halted        & rst_n;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (w_mem_stall | w_load_use),
      .i_clr (i_stall_cnt_clr),
      .o_cnt (o_stall_cnt)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed literal checkpoints followed by random
// traffic, compared every cycle against a rule-level model.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] id_rs1, id_rs2, ex_reg_dst;
   logic       id_rs1_vld, id_rs2_vld, ex_wr, ex_is_load, ex_br_taken;
   logic       mem_req, mem_ack, id_halt, resume, stall_cnt_clr;

   logic        a_pc, a_ifh, a_idh, a_exh, a_iff, a_idf, a_bub, a_mwb, a_hlt;
   logic [15:0] a_cnt;
   logic        b_pc, b_ifh, b_idh, b_exh, b_iff, b_idf, b_bub, b_mwb, b_hlt;
   logic [3:0]  b_cnt;
   logic [8:0]  vec_a, vec_b;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   hazard_ctrl u_dut (
      .clk(clk), .rst_n(rst_n),
      .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_rs1_vld(id_rs1_vld), .i_id_rs2_vld(id_rs2_vld),
      .i_ex_reg_dst(ex_reg_dst), .i_ex_wr(ex_wr), .i_ex_is_load(ex_is_load), .i_ex_br_taken(ex_br_taken),
      .i_mem_req(mem_req), .i_mem_ack(mem_ack), .i_id_halt(id_halt), .i_resume(resume),
      .i_stall_cnt_clr(stall_cnt_clr),
      .o_pc_hold(a_pc), .o_if_id_hold(a_ifh), .o_id_ex_hold(a_idh), .o_ex_mem_hold(a_exh),
      .o_if_id_flush(a_iff), .o_id_ex_flush(a_idf), .o_id_ex_bubble(a_bub), .o_mem_wb_bubble(a_mwb),
      .o_halted(a_hlt), .o_stall_cnt(a_cnt)
   );

   // Narrow-counter copy so saturation is reachable in a short run.
   hazard_ctrl #(.CNT_W(4)) u_dut_sat (
      .clk(clk), .rst_n(rst_n),
      .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_rs1_vld(id_rs1_vld), .i_id_rs2_vld(id_rs2_vld),
      .i_ex_reg_dst(ex_reg_dst), .i_ex_wr(ex_wr), .i_ex_is_load(ex_is_load), .i_ex_br_taken(ex_br_taken),
      .i_mem_req(mem_req), .i_mem_ack(mem_ack), .i_id_halt(id_halt), .i_resume(resume),
      .i_stall_cnt_clr(stall_cnt_clr),
      .o_pc_hold(b_pc), .o_if_id_hold(b_ifh), .o_id_ex_hold(b_idh), .o_ex_mem_hold(b_exh),
      .o_if_id_flush(b_iff), .o_id_ex_flush(b_idf), .o_id_ex_bubble(b_bub), .o_mem_wb_bubble(b_mwb),
      .o_halted(b_hlt), .o_stall_cnt(b_cnt)
   );

   // {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, if_id_flush, id_ex_flush, id_ex_bubble, mem_wb_bubble, halted}
   assign vec_a = {a_pc, a_ifh, a_idh, a_exh, a_iff, a_idf, a_bub, a_mwb, a_hlt};
   assign vec_b = {b_pc, b_ifh, b_idh, b_exh, b_iff, b_idf, b_bub, b_mwb, b_hlt};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit waiting_mem = 0;   // frozen behind an outstanding data access
   int drain_left  = 0;   // remaining unstalled drain cycles, 0 when not draining
   bit is_halted   = 0;
   int exp_cnt     = 0;
   int exp_cnt_s   = 0;

   always @(negedge clk) begin
      bit stalled, hit, draining, halt_now, event_stall;
      logic [8:0] e;
      if (!rst_n) begin
         waiting_mem = 0; drain_left = 0; is_halted = 0; exp_cnt = 0; exp_cnt_s = 0;
         check("m_rst_vec", vec_a, 0);
         check("m_rst_cnt", a_cnt, 0);
      end else begin
         hit = ex_is_load && ex_wr && ((id_rs1_vld && id_rs1 == ex_reg_dst) ||
                                        (id_rs2_vld && id_rs2 == ex_reg_dst));
         draining = (drain_left != 0);
         if (is_halted)        stalled = 0;
         else if (waiting_mem) stalled = !mem_ack;
         else                  stalled = mem_req && !mem_ack;
         halt_now = 0;
         e = '0;
         if (stalled) begin
            e = 9'b111100010;
         end else begin
            if (ex_br_taken)  e = e | 9'b000011000;
            else if (hit)     e = e | 9'b110000100;
            halt_now = id_halt && !ex_br_taken && !hit && !waiting_mem && !draining && !is_halted;
            if (draining || is_halted || halt_now) e = e | 9'b100010000;
            if (is_halted) e = e | 9'b000000001;
         end
         event_stall = stalled || (!ex_br_taken && hit);
         check("m_vec", vec_a, e);
         check("m_vec_sat", vec_b, e);
         check("m_cnt", a_cnt, exp_cnt);
         check("m_cnt_sat", b_cnt, exp_cnt_s);
         // state after the coming clock edge
         if (stalled) begin
            if (!draining) waiting_mem = 1;
         end else begin
            waiting_mem = 0;
            if (is_halted) begin
               if (resume) is_halted = 0;
            end else if (draining) begin
               drain_left--;
               if (drain_left == 0) is_halted = 1;
            end else if (halt_now) begin
               drain_left = 3;
            end
         end
         if (stall_cnt_clr) begin
            exp_cnt = 0; exp_cnt_s = 0;
         end else if (event_stall) begin
            if (exp_cnt < 65535) exp_cnt++;
            if (exp_cnt_s < 15)  exp_cnt_s++;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle();
      id_rs1 = 0; id_rs2 = 0; id_rs1_vld = 0; id_rs2_vld = 0;
      ex_reg_dst = 0; ex_wr = 0; ex_is_load = 0; ex_br_taken = 0;
      mem_req = 0; mem_ack = 0; id_halt = 0; resume = 0; stall_cnt_clr = 0;
   endtask

   task automatic load_use_r5();
      ex_is_load = 1; ex_wr = 1; ex_reg_dst = 4'd5; id_rs2 = 4'd5; id_rs2_vld = 1;
   endtask

   // Check a hand-computed expectation this cycle, then move past the next edge.
   task automatic lit(input string name, input logic [8:0] exp_vec, input int exp_c);
      @(negedge clk);
      check({name, "_vec"}, vec_a, exp_vec);
      check({name, "_cnt"}, a_cnt, exp_c);
      $display("txn %-12s vec=%b cnt=%0d", name, vec_a, a_cnt);
      @(posedge clk); #1;
   endtask

   localparam logic [8:0] HOLD  = 9'b111100010;
   localparam logic [8:0] FLUSH = 9'b000011000;
   localparam logic [8:0] LU    = 9'b110000100;
   localparam logic [8:0] DRN   = 9'b100010000;
   localparam logic [8:0] HLT   = 9'b100010001;

   initial begin
      idle();
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      lit("rst_state", 9'h0, 0);
      rst_n = 1;

      load_use_r5();                       lit("lu_hit", LU, 0);
      idle();                              lit("lu_after", 0, 1);
      load_use_r5(); id_rs2_vld = 0;
      id_rs1 = 4'd3; id_rs1_vld = 1;       lit("lu_novld", 0, 1);

      idle(); mem_req = 1;                 lit("mw1", HOLD, 1);
                                           lit("mw2", HOLD, 2);
                                           lit("mw3", HOLD, 3);
      mem_ack = 1;                         lit("mw_ack", 0, 4);
      idle();                              lit("mw_run", 0, 4);

      load_use_r5(); ex_br_taken = 1;      lit("br_lu", FLUSH, 4);
      idle();                              lit("br_lu_aft", 0, 4);

      ex_br_taken = 1; mem_req = 1;        lit("brm1", HOLD, 4);
                                           lit("brm2", HOLD, 5);
      mem_ack = 1;                         lit("brm_rel", FLUSH, 6);

      idle(); id_halt = 1;                 lit("halt", DRN, 6);
      idle();                              lit("drain1", DRN, 6);
      mem_req = 1;                         lit("drain_mem", HOLD, 6);
      mem_ack = 1;                         lit("drain2", DRN, 7);
      idle();                              lit("drain3", DRN, 7);
                                           lit("halted", HLT, 7);
      resume = 1;                          lit("halt_res", HLT, 7);
      idle();                              lit("resumed", 0, 7);

      // 10 load-use cycles: narrow counter saturates at 15, wide reaches 17.
      load_use_r5();
      repeat (10) begin @(posedge clk); #1; end
      idle();
      @(negedge clk);
      check("sat_hold", b_cnt, 15);
      check("cnt_17", a_cnt, 17);
      @(posedge clk); #1;
      load_use_r5(); stall_cnt_clr = 1;
      @(posedge clk); #1;
      idle();
      @(negedge clk);
      check("clr_wins", a_cnt, 0);
      check("clr_wins_sat", b_cnt, 0);
      @(posedge clk); #1;

      // asynchronous reset while frozen in MEM_WAIT
      mem_req = 1;
      @(posedge clk); #3;
      rst_n = 0;
      #1;
      check("async_vec", vec_a, 0);
      check("async_cnt", a_cnt, 0);
      @(posedge clk); #1;
      rst_n = 1; idle();
      lit("post_rst", 0, 0);

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         id_rs1        = 4'($urandom_range(0, 3));
         id_rs2        = 4'($urandom_range(0, 3));
         ex_reg_dst    = 4'($urandom_range(0, 3));
         id_rs1_vld    = 1'($urandom_range(0, 1));
         id_rs2_vld    = 1'($urandom_range(0, 1));
         ex_wr         = 1'($urandom_range(0, 3) != 0);
         ex_is_load    = 1'($urandom_range(0, 2) == 0);
         ex_br_taken   = 1'($urandom_range(0, 7) == 0);
         mem_req       = 1'($urandom_range(0, 3) == 0);
         mem_ack       = 1'($urandom_range(0, 1));
         id_halt       = 1'($urandom_range(0, 15) == 0);
         resume        = 1'($urandom_range(0, 7) == 0);
         stall_cnt_clr = 1'($urandom_range(0, 63) == 0);
         rst_n         = 1'($urandom_range(0, 199) != 0);
         @(posedge clk); #1;
      end
      rst_n = 1;
      idle();
      @(posedge clk); #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage CPU. It sits beside the EX-stage forwarding logic. It detects the load-use hazards that forwarding cannot cover, freezes the pipe while a data-memory access is outstanding, squashes wrong-path instructions after a taken branch, and sequences a halt/drain/resume. It drives the hold, flush and bubble controls of the PC and every pipeline register, and keeps a saturating stall-cycle counter.

## Interface
- REG_W, 4, register-address width (16 architectural registers)
- DRAIN_CYC, 3, cycles for a halt instruction to retire from ID/EX to WB
- CNT_W, 16, stall counter width
- clk  in  1  clock; all state on posedge
- rst_n  in  1  reset, asynchronous, active-low
- id_rs1, id_rs2  in  REG_W  source registers of the instruction in ID
- id_rs1_vld, id_rs2_vld  in  1  the ID instruction actually reads that source
- ex_reg_dst  in  REG_W  destination register of the instruction in EX
- ex_wr  in  1  EX instruction writes a register
- ex_is_load  in  1  EX instruction is a load
- ex_br_taken  in  1  branch/jump resolved taken in EX
- mem_req  in  1  MEM stage data access pending; level, held until acked
- mem_ack  in  1  data memory completes the access this cycle
- id_halt  in  1  halt decoded in ID
- resume  in  1  external restart from halt
- stall_cnt_clr  in  1  synchronous clear of stall_cnt
- pc_hold, if_id_hold, id_ex_hold, ex_mem_hold  out  1  freeze PC / stage register
- if_id_flush, id_ex_flush  out  1  load NOP into stage register
- id_ex_bubble  out  1  insert NOP into ID/EX while ID holds
- mem_wb_bubble  out  1  insert NOP into MEM/WB
- halted  out  1  core fully drained and stopped
- stall_cnt  out  CNT_W  saturating count of load-use plus memory-wait stall cycles

## Operation
- FSM states: RUN, MEM_WAIT, DRAIN, HALTED. Reset state is RUN. Reset drives every output and stall_cnt to 0 and clears the drain counter.
- Control outputs are Mealy, combinational from state and inputs. State and counters are registered.
- Event priority within a cycle, highest first: memory stall, branch flush, load-use, halt.
- Memory stall: active when mem_req & !mem_ack in RUN or DRAIN, or when in MEM_WAIT & !mem_ack.
  - Drives pc_hold, if_id_hold, id_ex_hold, ex_mem_hold and mem_wb_bubble.
  - Suppresses all other outputs that cycle.
  - From RUN goes to MEM_WAIT. From DRAIN stays in DRAIN with the drain counter frozen and returns there on ack.
  - In MEM_WAIT, mem_ack releases the hold in the same cycle and the next state is RUN.
- Branch flush: ex_br_taken with no memory stall drives if_id_flush and id_ex_flush. It suppresses load-use and halt, because those instructions are squashed.
  - A branch that is frozen in EX during MEM_WAIT is acted on in the cycle the hold releases.
- Load-use: ex_is_load & ex_wr & ((id_rs1_vld & id_rs1==ex_reg_dst) | (id_rs2_vld & id_rs2==ex_reg_dst)).
  - Register 0 is not special-cased.
  - Drives pc_hold, if_id_hold and id_ex_bubble for exactly one cycle. Forwarding from MEM covers the following cycle.
- Halt: id_halt in RUN with no higher-priority event drives pc_hold and if_id_flush, loads the drain counter with DRAIN_CYC and moves to DRAIN.
  - DRAIN keeps pc_hold and if_id_flush high, decrements the counter each unstalled cycle, and moves to HALTED when it reaches 0.
- HALTED: pc_hold and if_id_flush stay high and halted is 1. resume moves to RUN, and all three outputs drop in the next cycle.
  - resume outside HALTED is ignored.
- stall_cnt: +1 in each load-use cycle and each memory-stall cycle, saturating at all-ones. stall_cnt_clr wins over the increment.

## Timing
- Load-use detected in cycle N: stall outputs high in N only. The dependent instruction enters EX in N+2.
- Taken branch in EX in cycle N: flushes high in N. The target fetch is valid in N+1 (PC mux is external).
- mem_req rising in N without ack: holds from N. With ack in N+k, holds are high N..N+k-1 and low in N+k. A same-cycle ack causes no stall.
- Halt in ID at cycle N with no stalls: DRAIN N+1..N+3, halted=1 from N+4. Each memory-stall cycle during DRAIN delays halted by one cycle.
- Reset asserted mid-operation: state returns to RUN, all outputs go to 0 immediately (async), and stall_cnt is 0.

## Structure
- hazard_pkg holds:
  - the state enum (RUN, MEM_WAIT, DRAIN, HALTED)
  - default REG_W, DRAIN_CYC and CNT_W constants shared with the forwarding unit and decode
- One sub-module, sat_counter (width parameter, inc, clr, saturating), used for stall_cnt.

## Test plan
- EX: load to r5, ID reads rs2=r5 with id_rs2_vld=1 -> pc_hold/if_id_hold/id_ex_bubble high one cycle, stall_cnt 0->1. Same case with id_rs2_vld=0 -> no stall.
- mem_req high 4 cycles, mem_ack in the 4th -> all four holds and mem_wb_bubble high for 3 cycles, FSM RUN->MEM_WAIT->RUN, stall_cnt +3.
- ex_br_taken together with a load-use match -> only if_id_flush/id_ex_flush high, no bubble, stall_cnt unchanged.
- ex_br_taken held during a 2-cycle memory stall -> flushes low while stalled, high in the release cycle.
- id_halt, with one memory-stall cycle inserted during DRAIN -> halted rises 5 cycles after the halt cycle. resume -> pc_hold low the next cycle, state RUN.
- stall_cnt preloaded to 0xFFFF plus a load-use -> stays 0xFFFF. stall_cnt_clr with a simultaneous stall -> 0. Async reset mid-MEM_WAIT -> all outputs 0 and state RUN.
